axis_uart_rx_core: RTL and testbench
====================================

Name: axis_uart_rx_core

Overview:
UART receiver that deserializes an asynchronous serial line (rxd) into parallel words on an AXI4-Stream master interface. It runs on a single clock. A one-pulse-per-bit baud strobe (uart_ena) is generated externally, and rxd is sampled a fixed number of clocks after each strobe. It sits between a board-level RX pin and any AXIS consumer, such as a FIFO or stream sink.

Parameters:
PARITY_ENA, 0, 1 = a parity bit follows the data bits; 0 = no parity bit.
PARITY_TYPE, 0, 1 = odd parity (data ones plus parity bit is odd); 0 = even parity. Ignored when PARITY_ENA = 0.
STOP_BITS, 1, number of stop bits (1 or 2), each required to be 1.
DATA_BITS, 8, data bits per frame (5..8), sent LSB first; also the width of m_axis_tdata.
DELAY, 0, clocks after a uart_ena pulse at which rxd is sampled (0..bit period-1). It positions the sample point inside the bit.

Ports:
aclk  in  1  system clock; all logic is on the rising edge.
arst  in  1  synchronous reset, active-high.
uart_ena  in  1  baud strobe, one aclk-wide pulse per bit period.
rxd  in  1  serial input, idle high.
m_axis_tdata  out  DATA_BITS  received word, LSB = first data bit received.
m_axis_tvalid  out  1  word available.
m_axis_tready  in  1  consumer accepts word.

Behaviour:
- rxd passes through a 2-flop synchronizer before use. The synchronizer latency is fixed, and DELAY counts relative to uart_ena.
- Sample strobe: a counter is loaded on each uart_ena pulse. The "sample" event fires DELAY clocks later (same cycle if DELAY = 0). A new uart_ena pulse restarts the counter.
- FSM states: IDLE, START, DATA, PARITY, STOP. One bit is consumed per sample event.
  - IDLE: on a sample with rxd = 0, go to START-confirmed and then DATA. The start bit is consumed by that sample. rxd = 1 stays in IDLE.
  - DATA: shift in DATA_BITS samples, LSB first. Then go to PARITY if PARITY_ENA, else STOP.
  - PARITY: sample the bit and compute the error flag = (XOR of data bits XOR parity bit) != PARITY_TYPE.
  - STOP: sample STOP_BITS bits. A 0 on any of them is a framing error. After the last stop bit, return to IDLE.
- Frame completion:
  - If there is no parity error and no framing error, load the word into the output register and assert m_axis_tvalid on the next clock.
  - Otherwise discard the frame silently; tvalid is unaffected.
- Output handshake:
  - tvalid stays high with tdata stable until a cycle with tvalid & tready; it drops on the following clock.
  - Single-entry output register. If a frame completes while tvalid = 1 and tready = 0, the new word is dropped and the old word is kept.
  - If the handshake and frame completion occur in the same cycle, the new word is loaded and tvalid stays 1.
- Framing recovery: after a framing error the FSM returns to IDLE. It needs a sample with rxd = 1 before it accepts a new start bit, so a break (line held low) yields no words.
- Reset (arst = 1, synchronous), takes priority over everything:
  - FSM to IDLE, counters cleared, shift register 0.
  - m_axis_tdata = 0, m_axis_tvalid = 0.
  - Synchronizer flops = 1.
  - Reset mid-frame abandons the frame; no word is emitted.
- uart_ena asserted during reset is ignored.
- Latency: tvalid rises 1 clock after the sample event of the last stop bit.

Test Plan:
- Config PARITY_ENA=1, PARITY_TYPE=1, STOP_BITS=1, DATA_BITS=8, DELAY=3; aclk 100 ns; uart_ena every 10 clocks; bit time 1000 ns. Serial stream idle, 0, data bits 0,1,0,1,0,1,0,1, parity 1, stop 1 -> one word 0xAA with tvalid, accepted with tready held high.
- Next frame with data rotated, sent as 1,0,1,0,1,0,1,0 with parity 1 -> 0x55. Repeating the two frames continuously -> alternating 0xAA, 0x55 with no drops.
- Same frame 0xAA with parity bit 0 (bad odd parity) -> no tvalid pulse; the next good 0x55 frame is received.
- Stop bit forced to 0 -> frame discarded. With rxd held low afterwards, no further words appear until rxd returns high and a valid frame arrives.
- tready held low across two good frames (0xAA then 0x55) -> tdata stays 0xAA with tvalid high. After tready rises, 0xAA is accepted once, then tvalid = 0 (0x55 dropped).
- arst asserted mid-frame (after 4 data bits) for 5 clocks -> tvalid = 0, tdata = 0, no partial word. The next full frame 0xAA is received correctly.

Source files
------------

// File: rtl/axis_uart_rx_core.sv
// UART receiver: synchronizes rxd, samples it DELAY clocks after each baud
// strobe and delivers error-free frames on a single-entry AXI4-Stream master.
module axis_uart_rx_core #(
  parameter int PARITY_ENA  = 0,
  parameter int PARITY_TYPE = 0,
  parameter int STOP_BITS   = 1,
  parameter int DATA_BITS   = 8,
  parameter int DELAY       = 0
) (
  input  logic                 aclk,
  input  logic                 arst,
  input  logic                 uart_ena,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready
);

  localparam int CNT_W = (DELAY < 2) ? 1 : $clog2(DELAY + 1);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 rxd_meta;
  logic                 rxd_sync;
  logic [CNT_W-1:0]     dly_cnt;
  logic                 dly_armed;
  logic                 sample;
  logic [DATA_BITS-1:0] shift_q;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 par_err;
  logic                 frm_err;
  logic                 line_ok;
  logic                 shift_en;
  logic                 par_en;
  logic                 stop_en;
  logic                 frame_done;
  logic                 frame_good;

  always_ff @(posedge aclk) begin
    if (arst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
    end
  end

  // Each strobe reloads the delay counter; the sample fires when it reaches 1.
  always_ff @(posedge aclk) begin
    if (arst) begin
      dly_cnt   <= '0;
      dly_armed <= 1'b0;
    end else if (uart_ena) begin
      dly_cnt   <= CNT_W'(DELAY);
      dly_armed <= (DELAY != 0);
    end else if (dly_armed) begin
      dly_cnt <= dly_cnt - CNT_W'(1);
      if (dly_cnt == CNT_W'(1)) dly_armed <= 1'b0;
    end
  end

  assign sample = (DELAY == 0) ? uart_ena : (dly_armed && (dly_cnt == CNT_W'(1)));

  always_ff @(posedge aclk) begin
    if (arst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    stop_en    = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (sample && !rxd_sync && line_ok) state_next = S_START;
      end
      S_START: state_next = S_DATA;
      S_DATA: begin
        if (sample) begin
          shift_en = 1'b1;
          if (bit_cnt == BIT_W'(DATA_BITS - 1))
            state_next = (PARITY_ENA != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (sample) begin
          par_en     = 1'b1;
          state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (sample) begin
          stop_en = 1'b1;
          if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
            frame_done = 1'b1;
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // The current stop bit is folded in directly so the word can load on this edge.
  assign frame_good = frame_done && !par_err && !frm_err && rxd_sync;

  always_ff @(posedge aclk) begin
    if (arst) begin
      shift_q <= '0;
      bit_cnt <= '0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
      line_ok <= 1'b1;
    end else begin
      if (state_next != state)      bit_cnt <= '0;
      else if (shift_en || stop_en) bit_cnt <= bit_cnt + BIT_W'(1);
      if (shift_en) shift_q <= {rxd_sync, shift_q[DATA_BITS-1:1]};
      if (state == S_START) begin
        par_err <= 1'b0;
        frm_err <= 1'b0;
      end
      if (par_en) par_err <= ((^shift_q) ^ rxd_sync) != 1'(PARITY_TYPE);
      if (stop_en && !rxd_sync) frm_err <= 1'b1;
      // A framing error disarms start detection until the line is seen idle.
      if (state == S_IDLE && sample && rxd_sync) line_ok <= 1'b1;
      else if (stop_en && !rxd_sync)             line_ok <= 1'b0;
    end
  end

  // Handshake: tdata is held while tvalid is high; a word transfers on any edge
  // with tvalid & tready. A completing frame loads only if the slot is empty or
  // being emptied on the same edge; otherwise the new word is dropped.
  always_ff @(posedge aclk) begin
    if (arst) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
    end else if (frame_good && (!m_axis_tvalid || m_axis_tready)) begin
      m_axis_tdata  <= shift_q;
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tvalid && m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_uart_rx_core.sv
// Bench for axis_uart_rx_core: frame-level reference model of the output
// register, per-cycle compare, and literal checks on accepted words.
module tb_axis_uart_rx_core;

  localparam int PARITY_ENA  = 1;
  localparam int PARITY_TYPE = 1;
  localparam int STOP_BITS   = 1;
  localparam int DATA_BITS   = 8;
  localparam int DELAY       = 3;

  logic                 tb_data_clk = 1'b0;
  logic                 arst;
  logic                 uart_ena;
  logic                 rxd;
  logic [DATA_BITS-1:0] m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;

  int n_checks = 0;
  int n_fail   = 0;
  int rdy_mode = 1;
  logic chk_en = 1'b0;

  logic                 model_done = 1'b0;
  logic                 model_ok   = 1'b0;
  logic [DATA_BITS-1:0] model_word = '0;
  logic                 exp_valid  = 1'b0;
  logic [DATA_BITS-1:0] exp_data   = '0;
  logic [DATA_BITS-1:0] exp_q[$];
  logic [DATA_BITS-1:0] acc_q[$];

  always #50 tb_data_clk = ~tb_data_clk;

  axis_uart_rx_core #(
    .PARITY_ENA (PARITY_ENA),
    .PARITY_TYPE(PARITY_TYPE),
    .STOP_BITS  (STOP_BITS),
    .DATA_BITS  (DATA_BITS),
    .DELAY      (DELAY)
  ) dut (
    .aclk         (tb_data_clk),
    .arst         (arst),
    .uart_ena     (uart_ena),
    .rxd          (rxd),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Consumer: ready held low, held high, or randomized each cycle.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge tb_data_clk);
      #10;
      case (rdy_mode)
        0:       m_axis_tready = 1'b0;
        1:       m_axis_tready = 1'b1;
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Reference output register: a good frame completes on the edge flagged by
  // the driver; it loads if the slot is free or draining, else it is lost.
  always @(posedge tb_data_clk) begin
    logic hs;
    if (arst) begin
      exp_valid = 1'b0;
      exp_data  = '0;
    end else begin
      hs = exp_valid && m_axis_tready;
      if (hs) exp_q.push_back(exp_data);
      if (model_done && model_ok && (!exp_valid || m_axis_tready)) begin
        exp_data  = model_word;
        exp_valid = 1'b1;
      end else if (hs) begin
        exp_valid = 1'b0;
      end
    end
  end

  always @(posedge tb_data_clk) begin
    if (!arst && m_axis_tvalid && m_axis_tready) acc_q.push_back(m_axis_tdata);
  end

  initial begin
    forever begin
      @(negedge tb_data_clk);
      if (chk_en) begin
        check("cyc_tvalid", 32'(m_axis_tvalid), 32'(exp_valid));
        check("cyc_tdata", 32'(m_axis_tdata), 32'(exp_data));
      end
    end
  end

  // One bit period = 10 clocks; strobe on the first. The DUT samples the bit
  // on the third edge after the strobe edge, which is where a frame completes.
  task automatic send_bit(input logic b, input logic done, input logic ok,
                          input logic [DATA_BITS-1:0] word);
    @(negedge tb_data_clk);
    rxd      = b;
    uart_ena = 1'b1;
    @(negedge tb_data_clk);
    uart_ena = 1'b0;
    @(negedge tb_data_clk);
    @(negedge tb_data_clk);
    model_done = done;
    model_ok   = ok;
    model_word = word;
    @(negedge tb_data_clk);
    model_done = 1'b0;
    repeat (5) @(negedge tb_data_clk);
  endtask

  task automatic send_idle(input int n, input logic b);
    for (int i = 0; i < n; i++) send_bit(b, 1'b0, 1'b0, '0);
  endtask

  task automatic send_frame(input logic [DATA_BITS-1:0] data, input logic par_bad,
                            input logic stop_bad);
    logic ok;
    ok = !par_bad && !stop_bad;
    send_bit(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < DATA_BITS; i++) send_bit(data[i], 1'b0, 1'b0, '0);
    if (PARITY_ENA != 0) send_bit((^data) ^ 1'(PARITY_TYPE) ^ par_bad, 1'b0, 1'b0, '0);
    for (int s = 0; s < STOP_BITS; s++) begin
      if (s == STOP_BITS - 1) send_bit(!stop_bad, 1'b1, ok, data);
      else                    send_bit(1'b1, 1'b0, 1'b0, '0);
    end
  endtask

  initial begin
    int base;
    logic [DATA_BITS-1:0] aa;
    aa       = 8'hAA;
    arst     = 1'b1;
    uart_ena = 1'b0;
    rxd      = 1'b1;
    repeat (4) @(negedge tb_data_clk);
    arst   = 1'b0;
    chk_en = 1'b1;
    check("reset_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("reset_tdata", 32'(m_axis_tdata), 32'd0);

    // Back-to-back alternating frames with the consumer always ready.
    base = acc_q.size();
    send_idle(2, 1'b1);
    repeat (2) begin
      send_frame(8'hAA, 1'b0, 1'b0);
      send_frame(8'h55, 1'b0, 1'b0);
    end
    send_idle(1, 1'b1);
    check("alt_count", acc_q.size() - base, 32'd4);
    check("alt_w0", 32'(acc_q[base]), 32'hAA);
    check("alt_w1", 32'(acc_q[base+1]), 32'h55);
    check("alt_w2", 32'(acc_q[base+2]), 32'hAA);
    check("alt_w3", 32'(acc_q[base+3]), 32'h55);

    // Bad parity is dropped silently; the following frame still arrives.
    base = acc_q.size();
    send_frame(8'hAA, 1'b1, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0);
    send_idle(1, 1'b1);
    check("par_count", acc_q.size() - base, 32'd1);
    check("par_w0", 32'(acc_q[base]), 32'h55);

    // Framing error followed by a break: nothing until the line idles high.
    base = acc_q.size();
    send_frame(8'hAA, 1'b0, 1'b1);
    send_idle(6, 1'b0);
    check("break_count", acc_q.size() - base, 32'd0);
    send_idle(2, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b0);
    send_idle(1, 1'b1);
    check("brk_count", acc_q.size() - base, 32'd1);
    check("brk_w0", 32'(acc_q[base]), 32'hAA);

    // Backpressure: the second word is lost, the first is held.
    rdy_mode = 0;
    send_idle(1, 1'b1);
    base = acc_q.size();
    send_frame(8'hAA, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0);
    send_idle(1, 1'b1);
    check("bp_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("bp_tdata", 32'(m_axis_tdata), 32'hAA);
    check("bp_held", acc_q.size() - base, 32'd0);
    rdy_mode = 1;
    repeat (4) @(negedge tb_data_clk);
    check("bp_drain_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("bp_count", acc_q.size() - base, 32'd1);
    check("bp_w0", 32'(acc_q[base]), 32'hAA);

    // Reset mid-frame with a word pending and a strobe during reset.
    rdy_mode = 0;
    send_idle(1, 1'b1);
    send_frame(8'h55, 1'b0, 1'b0);
    send_idle(1, 1'b1);
    check("pre_rst_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("pre_rst_tdata", 32'(m_axis_tdata), 32'h55);
    base = acc_q.size();
    send_bit(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) send_bit(aa[i], 1'b0, 1'b0, '0);
    @(negedge tb_data_clk);
    arst     = 1'b1;
    uart_ena = 1'b1;
    rxd      = 1'b1;
    @(negedge tb_data_clk);
    uart_ena = 1'b0;
    repeat (4) @(negedge tb_data_clk);
    arst = 1'b0;
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tdata", 32'(m_axis_tdata), 32'd0);
    rdy_mode = 1;
    send_idle(2, 1'b1);
    check("rst_no_partial", acc_q.size() - base, 32'd0);
    send_frame(8'hAA, 1'b0, 1'b0);
    send_idle(1, 1'b1);
    check("rst_count", acc_q.size() - base, 32'd1);
    check("rst_w0", 32'(acc_q[base]), 32'hAA);

    // Random frames, random errors, random backpressure.
    rdy_mode = 2;
    for (int f = 0; f < 30; f++) begin
      logic [DATA_BITS-1:0] d;
      int r;
      d = DATA_BITS'($urandom_range(0, (1 << DATA_BITS) - 1));
      r = $urandom_range(0, 9);
      send_frame(d, r < 2, r == 2);
      send_idle($urandom_range(1, 3), 1'b1);
    end
    rdy_mode = 1;
    send_idle(2, 1'b1);

    check("acc_total", acc_q.size(), exp_q.size());
    for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++)
      check("acc_word", 32'(acc_q[i]), 32'(exp_q[i]));

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
